dram_arb_mem: RTL and testbench
===============================

Name: dram_arb_mem

Overview:
- Shared single-bank data memory for the multi-core processor. Serves N_CORES independent request channels.
- Each channel uses a req/ack handshake. Access latency and memory geometry are parametrised.
- A round-robin arbiter grants one access at a time. This gives every core fair, starvation-free access to the shared DRAM model.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, address width in bits per channel
DEPTH, 1024, number of words; valid addresses 0..DEPTH-1
N_CORES, 4, number of requester channels (>=1)
LAT, 2, cycles from grant to memory operation (>=1)

Ports:
clk  input  1  single system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  N_CORES  per-core request; held high until that core's ack is seen
we  input  N_CORES  per-core write enable (1 = write, 0 = read); valid while req is high
addr  input  N_CORES*ADDR_W  per-core address; core i at bits [i*ADDR_W +: ADDR_W]
wdata  input  N_CORES*DATA_W  per-core write data; core i at bits [i*DATA_W +: DATA_W]
rdata  output  DATA_W  read data, shared by all cores; valid only while some ack bit is high
ack  output  N_CORES  one-hot, one-cycle completion pulse to the granted core
grant_id  output  clog2(N_CORES) (min 1)  index of the core currently or last granted
busy  output  1  high whenever the FSM is not IDLE
err  output  1  one-cycle pulse with ack when the completed access addressed >= DEPTH

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; ack=0, err=0, rdata=0, grant_id=0, busy=0; round-robin pointer=0; latency counter=0.
  - Memory array contents are not cleared.
  - An access in flight is aborted: no write occurs and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from the pointer, wrapping modulo N_CORES.
  - On that edge, latch the selected core's we, addr and wdata; set grant_id; load counter=LAT-1; go to ACCESS.
  - If no req bit is high, stay in IDLE.
- ACCESS:
  - If counter != 0, decrement it.
  - If counter == 0, perform the operation on this edge, pulse ack[grant_id]=1, set pointer=(grant_id+1) mod N_CORES, and go to RESP.
  - Write: mem[addr]<=wdata.
  - Read: rdata<=mem[addr].
- RESP: ack=0, err=0; go to IDLE. rdata holds its value until the next read completes.
- Latency: req sampled at edge E gives ack high in the cycle after edge E+LAT. The earliest next grant is at edge E+LAT+2.
- Throughput: one access per LAT+2 cycles.
- Requester handshake rule: drop req (or present a new request) before the edge at which the FSM re-enters IDLE plus one. A req still high in IDLE is treated as a new request.
- Input stability: inputs are latched at grant. Changes to we, addr or wdata after grant have no effect on the access in progress.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped and memory is unchanged.
  - Read returns rdata=0.
  - ack is still issued, with err=1 in the same cycle.
- Simultaneous requests: exactly one grant per arbitration. The pointer guarantees each waiting core is served within N_CORES grants.
- Non-granted cores: req is ignored while busy; those cores keep req high and wait.
- N_CORES=1: the arbiter degenerates to a pass-through and grant_id=0.

Test Plan:
- LAT=2: core0 writes 0x0055 to addr 10; core0 then reads addr 10 -> ack[0] each time 3 cycles after the sampling edge; rdata=0x0055 during the read ack; err=0.
- All four cores raise req on the same cycle after reset, each writing its index+1 to addr 100+i -> ack order 0,1,2,3 on consecutive accesses 4 cycles apart; readback gives 1,2,3,4.
- Pointer at 2 (last grant core1); cores 0 and 3 request together -> core3 granted first, then core0.
- Core1 writes 0xBEEF to addr 1024 (DEPTH=1024) -> ack[1] and err=1; a read of addr 1024 returns 0 with err=1; addr 0 is unchanged.
- Core2 starts a write of 0x1234 to addr 5 (addr 5 previously 0x0007); rst_n pulsed low during ACCESS -> ack never asserts, busy=0 immediately; after reset, reading addr 5 returns 0x0007.
- Rebuild with LAT=1 and N_CORES=1: back-to-back reads with req held high -> ack every 3 cycles; grant_id stays 0.

Source files
------------

// File: rtl/dram_arb_mem.sv
// Shared single-bank data memory serving N_CORES req/ack channels through a
// round-robin arbiter and a fixed-latency IDLE/ACCESS/RESP access sequencer.
module dram_arb_mem #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int N_CORES = 4,
  parameter int LAT     = 2,
  localparam int GID_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic [N_CORES-1:0]        ack,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg;
  logic [GID_W-1:0]    ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [GID_W-1:0]    sel;
  logic                found;
  logic                in_range;
  logic                do_op;
  logic [IDX_W-1:0]    idx;

  // First requesting core at or above the pointer, wrapping modulo N_CORES.
  always_comb begin
    int j;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_CORES; i++) begin
      j = int'(ptr_reg) + i;
      if (j >= N_CORES) j = j - N_CORES;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = GID_W'(j);
      end
    end
  end

  assign in_range = {1'b0, addr_reg} < DEPTH_L;
  assign do_op    = (state_reg == ACCESS) && (cnt_reg == '0);
  assign idx      = addr_reg[IDX_W-1:0];

  // Array kept out of the reset domain so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (do_op && we_reg && in_range) mem[idx] <= wdata_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata     <= '0;
      ack       <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            we_reg    <= we[sel];
            addr_reg  <= addr[int'(sel)*ADDR_W +: ADDR_W];
            wdata_reg <= wdata[int'(sel)*DATA_W +: DATA_W];
            grant_id  <= sel;
            cnt_reg   <= CNT_W'(LAT - 1);
            busy      <= 1'b1;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            if (!we_reg) rdata <= in_range ? mem[idx] : '0;
            ack       <= N_CORES'(1) << grant_id;
            err       <= !in_range;
            ptr_reg   <= (grant_id == GID_W'(N_CORES - 1)) ? '0 : grant_id + 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          ack       <= '0;
          err       <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arb_mem.sv
// Bench for dram_arb_mem: a 4-core LAT=2 instance and a 1-core LAT=1 instance,
// checked through per-instance expectation queues popped on every ack.
module tb_dram_arb_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int N      = 4;
  localparam int LAT    = 2;
  localparam int LAT1   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [N-1:0]          req, we;
  logic [N*ADDR_W-1:0]   addr;
  logic [N*DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]     rdata;
  logic [N-1:0]          ack;
  logic [1:0]            grant_id;
  logic                  busy, err;

  logic [0:0]            req1, we1, ack1, gid1;
  logic [ADDR_W-1:0]     addr1;
  logic [DATA_W-1:0]     wdata1, rdata1;
  logic                  busy1, err1;

  dram_arb_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .N_CORES(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .grant_id(grant_id), .busy(busy), .err(err)
  );

  dram_arb_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .N_CORES(1), .LAT(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .grant_id(gid1), .busy(busy1), .err(err1)
  );

  typedef struct {
    int          gid;
    bit          is_wr;
    logic [15:0] rd;
    bit          er;
  } exp_t;

  typedef struct {
    int          core;
    bit          w;
    int          a;
    logic [15:0] d;
    logic [15:0] rd;
    bit          er;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ba[N], bd[N], bo[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expectation scoreboards: one pop per completion pulse.
  always @(negedge clk) begin
    if (ack !== '0) begin
      if (q0.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        e0 = q0.pop_front();
        $display("dut  ack=%b gid=%0d err=%0d rdata=%04h", ack, grant_id, err, rdata);
        chk("ack_onehot", 32'(ack), 32'(1) << e0.gid);
        chk("grant_id", 32'(grant_id), 32'(e0.gid));
        chk("err", 32'(err), 32'(e0.er));
        if (!e0.is_wr) chk("rdata", 32'(rdata), 32'(e0.rd));
      end
    end
  end

  always @(negedge clk) begin
    if (ack1 !== 1'b0) begin
      if (q1.size() == 0) begin
        chk("unexpected_ack1", 32'(ack1), 32'h0);
      end else begin
        e1 = q1.pop_front();
        $display("dut1 ack=%b gid=%0d err=%0d rdata=%04h", ack1, gid1, err1, rdata1);
        chk("grant_id1", 32'(gid1), 32'(e1.gid));
        chk("err1", 32'(err1), 32'(e1.er));
        if (!e1.is_wr) chk("rdata1", 32'(rdata1), 32'(e1.rd));
      end
    end
  end

  task automatic access0(input int core, input bit w, input int a, input logic [15:0] d,
                         input logic [15:0] rd, input bit er);
    exp_t e;
    int   t0, k;
    @(negedge clk);
    req[core] = 1'b1;
    we[core]  = w;
    addr[core*ADDR_W +: ADDR_W]  = ADDR_W'(a);
    wdata[core*DATA_W +: DATA_W] = d;
    e.gid = core; e.is_wr = w; e.rd = rd; e.er = er;
    q0.push_back(e);
    t0 = cyc;
    k  = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ack[core] !== 1'b1 && k < 50);
    chk("ack_seen", 32'(ack[core]), 32'h1);
    chk("latency", 32'(cyc - t0), 32'(LAT + 1));
    req[core] = 1'b0;
  endtask

  task automatic batch0(input logic [N-1:0] mask, input bit w, input int cnt);
    exp_t         e;
    logic [N-1:0] pending;
    int           last, n, k;
    @(negedge clk);
    for (int i = 0; i < cnt; i++) begin
      e.gid = bo[i]; e.is_wr = w; e.rd = 16'(bd[bo[i]]); e.er = 1'b0;
      q0.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(ba[i]);
        wdata[i*DATA_W +: DATA_W] = DATA_W'(bd[i]);
      end
    end
    pending = mask;
    last = 0; n = 0; k = 0;
    while (pending != '0 && k < 100) begin
      @(negedge clk);
      k++;
      if (ack != '0) begin
        if (n > 0) chk("ack_spacing", 32'(cyc - last), 32'(LAT + 2));
        last = cyc;
        n++;
        req     = req & ~ack;
        pending = pending & ~ack;
      end
    end
    chk("batch_done", 32'(pending), 32'h0);
  endtask

  initial begin
    int t0, n, k;
    exp_t e;
    tbl[0] = '{3, 1'b1, 0,    16'h0A0A, 16'h0000, 1'b0};
    tbl[1] = '{2, 1'b1, 5,    16'h0007, 16'h0000, 1'b0};
    tbl[2] = '{0, 1'b1, 10,   16'h0055, 16'h0000, 1'b0};
    tbl[3] = '{0, 1'b0, 10,   16'h0000, 16'h0055, 1'b0};
    tbl[4] = '{1, 1'b1, 1024, 16'hBEEF, 16'h0000, 1'b1};
    tbl[5] = '{1, 1'b0, 1024, 16'h0000, 16'h0000, 1'b1};
    tbl[6] = '{2, 1'b0, 0,    16'h0000, 16'h0A0A, 1'b0};
    tbl[7] = '{3, 1'b0, 5,    16'h0000, 16'h0007, 1'b0};

    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    req1 = '0; we1 = '0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      access0(tbl[i].core, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].er);

    // All four cores at once: pointer is 0, so service order is 0,1,2,3.
    for (int i = 0; i < N; i++) begin ba[i] = 100 + i; bd[i] = i + 1; bo[i] = i; end
    batch0(4'b1111, 1'b1, 4);
    for (int i = 0; i < N; i++) access0(i, 1'b0, 100 + i, 16'h0, 16'(i + 1), 1'b0);

    // Core1 leaves the pointer at 2; cores 0 and 3 contend -> 3 first.
    access0(1, 1'b0, 101, 16'h0, 16'h0002, 1'b0);
    ba[0] = 100; bd[0] = 1; ba[3] = 103; bd[3] = 4;
    bo[0] = 3; bo[1] = 0;
    batch0(4'b1001, 1'b0, 2);

    // Reset during ACCESS aborts the write to addr 5.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1;
    addr[2*ADDR_W +: ADDR_W] = 16'd5; wdata[2*DATA_W +: DATA_W] = 16'h1234;
    @(posedge clk);
    #2;
    chk("busy_granted", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ack", 32'(ack), 32'h0);
    chk("abort_rdata", 32'(rdata), 32'h0);
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    access0(0, 1'b0, 5, 16'h0, 16'h0007, 1'b0);

    // Single-core, LAT=1 instance: write, then back-to-back reads with req held.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd3; wdata1 = 16'h0077;
    e.gid = 0; e.is_wr = 1'b1; e.rd = 16'h0; e.er = 1'b0;
    q1.push_back(e);
    t0 = cyc; k = 0;
    do begin @(negedge clk); k++; end while (ack1 !== 1'b1 && k < 50);
    chk("ack1_seen", 32'(ack1), 32'h1);
    chk("latency1", 32'(cyc - t0), 32'(LAT1 + 1));
    req1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e.gid = 0; e.is_wr = 1'b0; e.rd = 16'h0077; e.er = 1'b0;
      q1.push_back(e);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd3;
    n = 0; k = 0; t0 = 0;
    while (n < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (ack1 == 1'b1) begin
        if (n > 0) chk("ack1_spacing", 32'(cyc - t0), 32'(LAT1 + 2));
        t0 = cyc;
        n++;
      end
    end
    req1 = 1'b0;
    chk("ack1_count", 32'(n), 32'h3);

    repeat (6) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
